// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE registers, IME control and vectored request/ack dispatch
module interrupt_controller (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        VBlank_interrupt,
  input  logic        STAT_interrupt,
  input  logic        Timer_interrupt,
  input  logic        Serial_interrupt,
  input  logic        Joypad_interrupt,
  output logic        irq_req,
  output logic [15:0] irq_vector,
  input  logic        irq_ack,
  input  logic        ime_ei,
  input  logic        ime_di,
  input  logic        ime_reti,
  input  logic        instr_done,
  output logic        wake
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nx;
  logic [4:0] src, prev, if_r, if_nx, pending;
  logic [7:0] ie_r;
  logic [2:0] sel, sel_nx, pri;
  logic ime, ime_nx, ei_pending, eip_nx, wr_if, wr_ie, acc;
  assign src = {Joypad_interrupt, Serial_interrupt, Timer_interrupt, STAT_interrupt, VBlank_interrupt};
  assign pending = if_r & ie_r[4:0];
  assign pri = pending[0] ? 3'd0 : pending[1] ? 3'd1 : pending[2] ? 3'd2 : pending[3] ? 3'd3 : 3'd4;
  assign irq_req = (state == REQ) && pending[sel];
  assign acc = irq_req && irq_ack;
  assign irq_vector = irq_req ? 16'h0040 + {10'b0, sel, 3'b0} : 16'h0000;
  assign wake = |pending;
  assign wr_if = cpu_we && (cpu_addr == 16'hFF0F);
  assign wr_ie = cpu_we && (cpu_addr == 16'hFFFF);
  assign cpu_rdata = (cpu_re && !cpu_we && cpu_addr == 16'hFF0F) ? {3'b111, if_r} :
                     (cpu_re && !cpu_we && cpu_addr == 16'hFFFF) ? ie_r : 8'hzz;
  // IF update: CPU write, then ack clear, then new edges (a set beats a clear)
  always_comb begin
    if_nx = wr_if ? cpu_wdata[4:0] : if_r;
    if (acc) if_nx[sel] = 1'b0;
    if_nx = if_nx | (src & ~prev);
  end
  // IME: DI and dispatch clear; RETI sets; EI takes effect one instruction later
  always_comb begin
    ime_nx = ime;
    eip_nx = ei_pending;
    if (ime_di || acc) begin
      ime_nx = 1'b0;
      eip_nx = 1'b0;
    end else begin
      if (ime_reti) ime_nx = 1'b1;
      if (ime_ei) eip_nx = 1'b1;
      else if (instr_done && ei_pending) begin
        ime_nx = 1'b1;
        eip_nx = 1'b0;
      end
    end
  end
  // Dispatch: latch the winner at an instruction boundary, hold until ack or cancel
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    if (state == IDLE && ime && |pending && instr_done) begin
      state_nx = REQ;
      sel_nx = pri;
    end else if (state == REQ && (irq_ack || !pending[sel])) state_nx = IDLE;
  end
  // State registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      sel <= 3'd0;
      prev <= 5'd0;
      if_r <= 5'd0;
      ie_r <= 8'd0;
      ime <= 1'b0;
      ei_pending <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      prev <= src;
      if_r <= if_nx;
      ie_r <= wr_ie ? cpu_wdata : ie_r;
      ime <= ime_nx;
      ei_pending <= eip_nx;
    end
  end
endmodule
